// File: rtl/tlda_cmd_master_if.sv
// Command handshake and Avalon-MM master bus of the line-draw command master.
// The master modport is the block's view; the slave modport is the view of
// whatever sits on the other side (command source plus accelerator slave).
interface tlda_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_x0;
   logic [8:0]  cmd_x1;
   logic [7:0]  cmd_y0;
   logic [7:0]  cmd_y1;
   logic [15:0] cmd_color;
   logic [8:0]  cmd_thickness;
   logic [31:0] cmd_base_addr;

   logic [2:0]  master_address;
   logic        master_chipselect;
   logic        master_read;
   logic        master_write;
   logic [31:0] master_writedata;
   logic [31:0] master_readdata;
   logic        master_waitrequest;

   modport master (
      input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_thickness, cmd_base_addr,
      output cmd_ready,
      output master_address, master_chipselect, master_read, master_write, master_writedata,
      input  master_readdata, master_waitrequest
   );

   modport slave (
      output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_thickness, cmd_base_addr,
      input  cmd_ready,
      input  master_address, master_chipselect, master_read, master_write, master_writedata,
      output master_readdata, master_waitrequest
   );
endinterface

// File: rtl/tlda_cmd_master.sv
// Line-draw command master: turns one accepted line command into the accelerator's
// register write sequence over Avalon-MM, then polls STATUS until the line is done.
// All bus strobes and status outputs are registered, decoded from the next state.
module tlda_cmd_master #(
   parameter int unsigned POLL_GAP       = 4,       // idle cycles between STATUS reads, >= 1
   parameter int unsigned TIMEOUT_CYCLES = 1000000  // GO-to-done limit, 0 disables
) (
   input  logic              clk,
   input  logic              resetn,
   tlda_cmd_master_if.master bus,
   output logic              busy,
   output logic              timeout_err,
   output logic [15:0]       lines_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_BASE, S_WR_START, S_WR_END, S_WR_COLOR,
      S_WR_THICK, S_WR_GO, S_GAP, S_RD_STATUS
   } state_e;

   localparam logic [2:0]  REG_STATUS = 3'd0;
   localparam logic [2:0]  REG_GO     = 3'd1;
   localparam logic [2:0]  REG_START  = 3'd2;
   localparam logic [2:0]  REG_END    = 3'd3;
   localparam logic [2:0]  REG_COLOR  = 3'd4;
   localparam logic [2:0]  REG_THICK  = 3'd5;
   localparam logic [2:0]  REG_BASE   = 3'd6;
   localparam logic [31:0] GAP_RELOAD = 32'(POLL_GAP - 1);
   localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] start_q, start_d, end_q, end_d, color_q, color_d, thick_q, thick_d;
   logic [31:0] base_q, base_d, last_base_q, last_base_d;
   logic        base_valid_q, base_valid_d;
   logic [31:0] gap_cnt_q, gap_cnt_d, tmo_cnt_q, tmo_cnt_d, tmo_next;
   logic        tmo_hit, xfer_ok;
   logic        cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
   logic [2:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        cmd_ready_q, cmd_ready_d, busy_q, busy_d, timeout_err_q, timeout_err_d;
   logic [15:0] lines_done_q, lines_done_d;
   logic        unused_readdata;

   // Only the done bit of STATUS matters.
   assign unused_readdata = ^bus.master_readdata[31:1];

   // Next-state, command latch, counters and registered-output decode.
   always_comb begin
      // NOTE: every _d takes its hold value before any branch, so no path through this block infers a latch.
      state_d       = state_q;
      start_d       = start_q;
      end_d         = end_q;
      color_d       = color_q;
      thick_d       = thick_q;
      base_d        = base_q;
      last_base_d   = last_base_q;
      base_valid_d  = base_valid_q;
      gap_cnt_d     = gap_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
      lines_done_d  = lines_done_q;

      xfer_ok  = !bus.master_waitrequest;
      tmo_next = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
      tmo_hit  = (TMO_LIMIT != '0) && (tmo_next >= TMO_LIMIT);

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               start_d       = {15'b0, bus.cmd_y0, bus.cmd_x0};
               end_d         = {15'b0, bus.cmd_y1, bus.cmd_x1};
               color_d       = {16'b0, bus.cmd_color};
               thick_d       = {23'b0, bus.cmd_thickness};
               base_d        = bus.cmd_base_addr;
               timeout_err_d = 1'b0;
               // Skip the BASE_ADDR write when the accelerator already holds this base.
               state_d = (!base_valid_q || bus.cmd_base_addr != last_base_q) ? S_WR_BASE : S_WR_START;
            end
         end
         S_WR_BASE: begin
            if (xfer_ok) begin
               base_valid_d = 1'b1;
               last_base_d  = base_q;
               state_d      = S_WR_START;
            end
         end
         S_WR_START: if (xfer_ok) state_d = S_WR_END;
         S_WR_END:   if (xfer_ok) state_d = S_WR_COLOR;
         S_WR_COLOR: if (xfer_ok) state_d = S_WR_THICK;
         S_WR_THICK: if (xfer_ok) state_d = S_WR_GO;
         S_WR_GO: begin
            if (xfer_ok) begin
               gap_cnt_d = GAP_RELOAD;
               tmo_cnt_d = '0;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            tmo_cnt_d = tmo_next;
            if (tmo_hit) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else if (gap_cnt_q == '0) begin
               state_d = S_RD_STATUS;
            end else begin
               gap_cnt_d = gap_cnt_q - 32'd1;
            end
         end
         S_RD_STATUS: begin
            tmo_cnt_d = tmo_next;
            // A stalled read is always finished before the timeout is honoured.
            if (xfer_ok) begin
               if (bus.master_readdata[0]) begin
                  lines_done_d = lines_done_q + 16'd1;
                  state_d      = S_IDLE;
               end else if (tmo_hit) begin
                  timeout_err_d = 1'b1;
                  state_d       = S_IDLE;
               end else begin
                  gap_cnt_d = GAP_RELOAD;
                  state_d   = S_GAP;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = REG_STATUS;
      wdata_d = '0;
      case (state_d)
         S_WR_BASE:   begin wr_d = 1'b1; addr_d = REG_BASE;  wdata_d = base_d;  end
         S_WR_START:  begin wr_d = 1'b1; addr_d = REG_START; wdata_d = start_d; end
         S_WR_END:    begin wr_d = 1'b1; addr_d = REG_END;   wdata_d = end_d;   end
         S_WR_COLOR:  begin wr_d = 1'b1; addr_d = REG_COLOR; wdata_d = color_d; end
         S_WR_THICK:  begin wr_d = 1'b1; addr_d = REG_THICK; wdata_d = thick_d; end
         S_WR_GO:     begin wr_d = 1'b1; addr_d = REG_GO;    wdata_d = 32'h1;   end
         S_RD_STATUS: rd_d = 1'b1;
         default:     ;
      endcase
      cs_d        = wr_d | rd_d;
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and registered outputs; reset drops every strobe at once and forgets the last base.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         start_q       <= '0;
         end_q         <= '0;
         color_q       <= '0;
         thick_q       <= '0;
         base_q        <= '0;
         last_base_q   <= '0;
         base_valid_q  <= 1'b0;
         gap_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         cs_q          <= 1'b0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         lines_done_q  <= '0;
      end else begin
         // NOTE: non-blocking assignment makes every flop capture pre-edge values, independent of statement order.
         state_q       <= state_d;
         start_q       <= start_d;
         end_q         <= end_d;
         color_q       <= color_d;
         thick_q       <= thick_d;
         base_q        <= base_d;
         last_base_q   <= last_base_d;
         base_valid_q  <= base_valid_d;
         gap_cnt_q     <= gap_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         cs_q          <= cs_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cmd_ready_q   <= cmd_ready_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         lines_done_q  <= lines_done_d;
      end
   end

   assign bus.cmd_ready         = cmd_ready_q;
   assign bus.master_chipselect = cs_q;
   assign bus.master_read       = rd_q;
   assign bus.master_write      = wr_q;
   assign bus.master_address    = addr_q;
   assign bus.master_writedata  = wdata_q;
   assign busy                  = busy_q;
   assign timeout_err           = timeout_err_q;
   assign lines_done            = lines_done_q;

endmodule
